prim_byte_packer: RTL and testbench

Byte-granular packer that generalises the bit-mask packer to independent input/output widths and arbitrary, non-contiguous byte strobes. It compacts the strobed input bytes into a byte stream and emits full OutW-bit words, or a final partial word on flush. It sits between a narrow producer (e.g. a DMA or register-write path) and a wide consumer (FIFO, memory or bus master), providing ready/valid on both sides with no combinational valid_i -> ready_o path.

---
 rtl/prim_byte_packer.sv | 155 +++++++++++++++
 tb/tb_prim_byte_packer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/prim_byte_packer.sv
// prim_byte_packer: compacts byte-strobed InW-bit input words into a byte
// stream and emits full OutW-bit words, or a final partial word on flush.
// Optional macro PRIM_BYTE_PACKER_ERR_EN adds the sticky err_o protocol flag.
module prim_byte_packer #(
  parameter int unsigned InW  = 32,
  parameter int unsigned OutW = 64,
  localparam int unsigned CntW = $clog2(InW / 8 + OutW / 8 + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [InW-1:0]    data_i,
  input  logic [InW/8-1:0]  strb_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [OutW-1:0]   data_o,
  output logic [OutW/8-1:0] strb_o,
  input  logic              ready_i,
  input  logic              flush_i,
  output logic              flush_done_o,
  output logic [CntW-1:0]   cnt_o
`ifdef PRIM_BYTE_PACKER_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int unsigned NI   = InW / 8;
  localparam int unsigned NO   = OutW / 8;
  localparam int unsigned NS   = NI + NO;
  localparam int unsigned IdxW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      slot_q [NS];
  logic [7:0]      slot_d [NS];
  logic            valid_q, valid_d;
  logic            ready_q, ready_d;
  logic            flush_done_q, flush_done_d;
  logic [OutW-1:0] data_q, data_d;
  logic [NO-1:0]   strb_q, strb_d;
`ifdef PRIM_BYTE_PACKER_ERR_EN
  logic            err_q, err_d;
`endif

  logic            ack_in, ack_out;
  logic [CntW-1:0] rm, cnt_sh, pos;

  // Handshakes; with error checking, input offered alongside flush is refused.
  always_comb begin
    ack_out = valid_q & ready_i;
`ifdef PRIM_BYTE_PACKER_ERR_EN
    ack_in  = valid_i & ready_q & ~flush_i;
`else
    ack_in  = valid_i & ready_q;
`endif
  end

  // Storage update: drop the emitted word first, then append compacted bytes.
  always_comb begin
    slot_d = slot_q;
    rm     = '0;
    cnt_sh = cnt_q;
    if (ack_out) begin
      rm = (cnt_q > CntW'(NO)) ? CntW'(NO) : cnt_q;
      for (int i = 0; i < int'(NS); i++) begin
        if (i + int'(rm) < int'(NS)) slot_d[IdxW'(i)] = slot_q[IdxW'(i + int'(rm))];
        else                         slot_d[IdxW'(i)] = '0;
      end
      cnt_sh = cnt_q - rm;
    end
    pos = cnt_sh;
    if (ack_in) begin
      for (int k = 0; k < int'(NI); k++) begin
        if (strb_i[k] && (int'(pos) < int'(NS))) begin
          slot_d[IdxW'(pos)] = data_i[8*k +: 8];
          pos = pos + CntW'(1);
        end
      end
    end
    cnt_d = pos;
  end

  // Flush FSM and sticky error flag.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_i) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef PRIM_BYTE_PACKER_ERR_EN
    err_d = err_q;
    if (valid_i && ((state_q == DRAIN) || flush_i)) err_d = 1'b1;
`endif
  end

  // Output values for the next cycle, computed from next-state so outputs are flops.
  always_comb begin
    ready_d      = (state_d == IDLE) && (cnt_d <= CntW'(NO));
    valid_d      = (cnt_d >= CntW'(NO)) || ((state_d == DRAIN) && (cnt_d != '0));
    flush_done_d = (state_d == DRAIN) && (cnt_d == '0);
    data_d       = '0;
    strb_d       = '0;
    for (int i = 0; i < int'(NO); i++) begin
      strb_d[i] = (CntW'(i) < cnt_d);
      if (strb_d[i]) data_d[8*i +: 8] = slot_d[IdxW'(i)];
    end
  end

  // All state, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      slot_q       <= '{default: '0};
      valid_q      <= 1'b0;
      ready_q      <= 1'b1;
      flush_done_q <= 1'b0;
      data_q       <= '0;
      strb_q       <= '0;
`ifdef PRIM_BYTE_PACKER_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      flush_done_q <= flush_done_d;
      data_q       <= data_d;
      strb_q       <= strb_d;
`ifdef PRIM_BYTE_PACKER_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign ready_o      = ready_q;
  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign strb_o       = strb_q;
  assign flush_done_o = flush_done_q;
  assign cnt_o        = cnt_q;
`ifdef PRIM_BYTE_PACKER_ERR_EN
  assign err_o        = err_q;
`endif

endmodule

// File: tb/tb_prim_byte_packer.sv
// Directed testbench for prim_byte_packer (InW = 32, OutW = 64).
module tb_prim_byte_packer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic [3:0]  strb_i;
  logic        ready_o;
  logic        valid_o;
  logic [63:0] data_o;
  logic [7:0]  strb_o;
  logic        ready_i;
  logic        flush_i;
  logic        flush_done_o;
  logic [3:0]  cnt_o;
`ifdef PRIM_BYTE_PACKER_ERR_EN
  logic        err_o;
`endif

  int total = 0;
  int bad   = 0;

  prim_byte_packer #(.InW(32), .OutW(64)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .strb_i       (strb_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .strb_o       (strb_o),
    .ready_i      (ready_i),
    .flush_i      (flush_i),
    .flush_done_o (flush_done_o),
    .cnt_o        (cnt_o)
`ifdef PRIM_BYTE_PACKER_ERR_EN
    ,
    .err_o        (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] s);
    valid_i = 1'b1;
    data_i  = d;
    strb_i  = s;
    step();
    valid_i = 1'b0;
  endtask

  logic [63:0] hold_data;
  logic        stable;
  logic        saw_done;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; strb_i = '0;
    ready_i = 1'b1; flush_i = 1'b0;
    step(); step();
    rst_i = 1'b0;

    // Reset state
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_data",  data_o, 64'd0);
    chk("rst_strb",  64'(strb_o), 64'd0);
    chk("rst_done",  64'(flush_done_o), 64'd0);
    chk("rst_cnt",   64'(cnt_o), 64'd0);
`ifdef PRIM_BYTE_PACKER_ERR_EN
    chk("rst_err",   64'(err_o), 64'd0);
`endif

    // Full pack
    send(32'h03020100, 4'hF);
    chk("full_cnt4", 64'(cnt_o), 64'd4);
    send(32'h07060504, 4'hF);
    chk("full_valid", 64'(valid_o), 64'd1);
    chk("full_data",  data_o, 64'h0706050403020100);
    chk("full_strb",  64'(strb_o), 64'hFF);
    step();
    chk("full_cnt0",  64'(cnt_o), 64'd0);
    chk("full_vld0",  64'(valid_o), 64'd0);

    // Zero-strobe word changes nothing
    send(32'hFFFFFFFF, 4'h0);
    chk("zstrb_cnt", 64'(cnt_o), 64'd0);
    chk("zstrb_vld", 64'(valid_o), 64'd0);

    // Sparse strobes
    send(32'hDDCCBBAA, 4'b1010);
    chk("sparse_cnt2", 64'(cnt_o), 64'd2);
    send(32'h44332211, 4'hF);
    send(32'h00000055, 4'b0001);
    send(32'h00000066, 4'b0001);
    chk("sparse_valid", 64'(valid_o), 64'd1);
    chk("sparse_data",  data_o, 64'h66554433_2211DDBB);
    chk("sparse_strb",  64'(strb_o), 64'hFF);
    step();
    chk("sparse_cnt0",  64'(cnt_o), 64'd0);

    // Backpressure
    ready_i = 1'b0;
    send(32'h13121110, 4'hF);
    send(32'h17161514, 4'hF);
    send(32'h1B1A1918, 4'hF);
    chk("bp_cnt12",  64'(cnt_o), 64'd12);
    chk("bp_ready0", 64'(ready_o), 64'd0);
    chk("bp_valid",  64'(valid_o), 64'd1);
    chk("bp_data",   data_o, 64'h1716151413121110);
    hold_data = data_o;
    stable    = 1'b1;
    valid_i = 1'b1; data_i = 32'hEEEEEEEE; strb_i = 4'hF;
    for (int i = 0; i < 20; i++) begin
      step();
      if (valid_o !== 1'b1 || data_o !== hold_data) stable = 1'b0;
    end
    chk("bp_stable",  64'(stable), 64'd1);
    chk("bp_cnt_hold", 64'(cnt_o), 64'd12);
    valid_i = 1'b0;
    ready_i = 1'b1;
    step();
    chk("bp_cnt4",   64'(cnt_o), 64'd4);
    chk("bp_ready1", 64'(ready_o), 64'd1);
    chk("bp_rem",    data_o, 64'h1B1A1918);

    // Simultaneous accept and emit
    send(32'h23222120, 4'hF);
    chk("sim_cnt8",  64'(cnt_o), 64'd8);
    chk("sim_data8", data_o, 64'h232221201B1A1918);
    send(32'h33323130, 4'hF);
    chk("sim_cnt4",  64'(cnt_o), 64'd4);
    chk("sim_data4", data_o, 64'h33323130);
    chk("sim_strb4", 64'(strb_o), 64'h0F);

    // Flush the remaining 4 bytes
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("fl4_valid", 64'(valid_o), 64'd1);
    chk("fl4_ready", 64'(ready_o), 64'd0);
    step();
    chk("fl4_done",  64'(flush_done_o), 64'd1);
    chk("fl4_cnt",   64'(cnt_o), 64'd0);
    step();
    chk("fl4_done0", 64'(flush_done_o), 64'd0);
    chk("fl4_rdy1",  64'(ready_o), 64'd1);

    // Flush of 3 bytes
    send(32'h000C0B0A, 4'b0111);
    chk("fl3_cnt",   64'(cnt_o), 64'd3);
    chk("fl3_vld0",  64'(valid_o), 64'd0);
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("fl3_valid", 64'(valid_o), 64'd1);
    chk("fl3_data",  data_o, 64'h0C0B0A);
    chk("fl3_strb",  64'(strb_o), 64'h07);
    chk("fl3_ready", 64'(ready_o), 64'd0);
    chk("fl3_nodone", 64'(flush_done_o), 64'd0);
    step();
    chk("fl3_done",  64'(flush_done_o), 64'd1);
    chk("fl3_cnt0",  64'(cnt_o), 64'd0);
    chk("fl3_vld_off", 64'(valid_o), 64'd0);
    step();
    chk("fl3_done0", 64'(flush_done_o), 64'd0);
    chk("fl3_rdy1",  64'(ready_o), 64'd1);

    // Flush with nothing stored
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("fl0_done",  64'(flush_done_o), 64'd1);
    chk("fl0_valid", 64'(valid_o), 64'd0);
    step();
    chk("fl0_done0", 64'(flush_done_o), 64'd0);
    chk("fl0_rdy",   64'(ready_o), 64'd1);

    // Reset mid-DRAIN
    send(32'h04030201, 4'hF);
    send(32'h00000005, 4'b0001);
    chk("rd_cnt5", 64'(cnt_o), 64'd5);
    ready_i = 1'b0;
    flush_i = 1'b1; step(); flush_i = 1'b0;
    chk("rd_valid", 64'(valid_o), 64'd1);
    chk("rd_data",  data_o, 64'h0504030201);
`ifdef PRIM_BYTE_PACKER_ERR_EN
    valid_i = 1'b1; data_i = 32'h99999999; strb_i = 4'hF;
    step();
    valid_i = 1'b0;
    chk("rd_err1",   64'(err_o), 64'd1);
    chk("rd_cnt_keep", 64'(cnt_o), 64'd5);
    step();
    chk("rd_err_sticky", 64'(err_o), 64'd1);
`endif
    rst_i = 1'b1; step(); rst_i = 1'b0;
    chk("rd_valid0", 64'(valid_o), 64'd0);
    chk("rd_cnt0",   64'(cnt_o), 64'd0);
    chk("rd_ready1", 64'(ready_o), 64'd1);
`ifdef PRIM_BYTE_PACKER_ERR_EN
    chk("rd_err0",   64'(err_o), 64'd0);
`endif
    saw_done = flush_done_o;
    for (int i = 0; i < 4; i++) begin
      step();
      if (flush_done_o) saw_done = 1'b1;
    end
    chk("rd_nodone", 64'(saw_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
